// File: rtl/serv_rf_arb.sv
// serv_rf_arb: register-file RAM arbiter/sequencer between serv_rf_ram_if
// and serv_rf_ram.
//   - IDLE: core RAM traffic is a combinational passthrough.
//   - INIT/CLR: zero-fills the whole RAM (GPRs + CSR words) after reset or
//     when i_clr_req is raised while the core is halted.
//   - DRD/DWR: 32-bit debug GPR access, sequenced as BEATS narrow RAM beats,
//     LSB beat first; ACK gives a one-cycle completion pulse.
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_c_*, o_c_rdata           core side of the RAM
//   i_halted, i_clr_req        clear request (accepted only while halted)
//   i_dbg_*, o_dbg_*           debug request / completion
//   o_busy                     arbiter owns the RAM (state != IDLE)
//   o_waddr..o_ren, i_rdata    RAM side (1-cycle synchronous read)
module serv_rf_arb #(
  parameter  int WIDTH        = 8,
  parameter  int RF_COUNT     = 16,
  parameter  int CSR_COUNT    = 0,
  parameter  int CLR_ON_RESET = 1,
  localparam int BEATS        = 32 / WIDTH,
  localparam int DEPTH        = (RF_COUNT + CSR_COUNT) * BEATS,
  localparam int L2D          = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [L2D-1:0]   i_c_waddr,
  input  logic [WIDTH-1:0] i_c_wdata,
  input  logic             i_c_wen,
  input  logic [L2D-1:0]   i_c_raddr,
  input  logic             i_c_ren,
  output logic [WIDTH-1:0] o_c_rdata,
  input  logic             i_halted,
  input  logic             i_clr_req,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [4:0]       i_dbg_reg,
  input  logic [31:0]      i_dbg_wdata,
  output logic             o_dbg_ack,
  output logic             o_dbg_err,
  output logic [31:0]      o_dbg_rdata,
  output logic             o_busy,
  output logic [L2D-1:0]   o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen,
  output logic [L2D-1:0]   o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata
);

  // One counter serves both the clear sweep (0..DEPTH-1) and the debug
  // beat index (0..BEATS, the extra step being the last read capture).
  localparam int CW = L2D + 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CLR, S_DRD, S_DWR, S_ACK
  } state_t;

  localparam state_t RST_STATE = (CLR_ON_RESET != 0) ? S_INIT : S_IDLE;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      reg_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic            clr_go, dbg_go, dbg_bad, dbg_x0;
  logic [L2D-1:0]  beat_addr;
  logic [WIDTH-1:0] beat_wdata;

  // Clear outranks debug; a losing debug request simply stays pending.
  assign clr_go  = i_clr_req & i_halted;
  assign dbg_go  = i_dbg_req & i_halted & ~clr_go;
  assign dbg_bad = 32'(i_dbg_reg) >= 32'(RF_COUNT);
  assign dbg_x0  = (i_dbg_reg == 5'd0);

  assign beat_addr  = L2D'(32'(reg_q) * BEATS + 32'(cnt_q));
  assign beat_wdata = WIDTH'(wdata_q >> (32'(cnt_q) * WIDTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_CLR;
      S_IDLE: begin
        if (clr_go)
          state_d = S_CLR;
        else if (dbg_go) begin
          // Out-of-range and x0 accesses never touch the RAM.
          if (dbg_bad || dbg_x0) state_d = S_ACK;
          else if (i_dbg_we)     state_d = S_DWR;
          else                   state_d = S_DRD;
        end
      end
      S_CLR: if (cnt_q == CW'(DEPTH - 1)) state_d = S_IDLE;
      S_DRD: if (cnt_q == CW'(BEATS))     state_d = S_ACK;
      S_DWR: if (cnt_q == CW'(BEATS - 1)) state_d = S_ACK;
      S_ACK: state_d = S_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;

      if (state_q == S_IDLE && dbg_go) begin
        reg_q   <= i_dbg_reg;
        wdata_q <= i_dbg_wdata;
        err_q   <= dbg_bad;
        if (!i_dbg_we && !dbg_bad && dbg_x0) rdata_q <= '0;
      end

      // Beat b was issued at cnt=b; its data is on i_rdata while cnt=b+1.
      if (state_q == S_DRD) begin
        for (int b = 0; b < BEATS; b++)
          if (cnt_q == CW'(b + 1)) rdata_q[b*WIDTH +: WIDTH] <= i_rdata;
      end
    end
  end

  always_comb begin
    o_waddr = '0;
    o_wdata = '0;
    o_wen   = 1'b0;
    o_raddr = '0;
    o_ren   = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_waddr = i_c_waddr;
        o_wdata = i_c_wdata;
        o_wen   = i_c_wen;
        o_raddr = i_c_raddr;
        o_ren   = i_c_ren;
      end
      S_CLR: begin
        o_waddr = cnt_q[L2D-1:0];
        o_wen   = 1'b1;
      end
      S_DRD: begin
        if (cnt_q < CW'(BEATS)) begin
          o_raddr = beat_addr;
          o_ren   = 1'b1;
        end
      end
      S_DWR: begin
        o_waddr = beat_addr;
        o_wdata = beat_wdata;
        o_wen   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_c_rdata   = i_rdata;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_ack   = (state_q == S_ACK);
  assign o_dbg_err   = (state_q == S_ACK) & err_q;
  assign o_dbg_rdata = rdata_q;

endmodule

// File: tb/tb_serv_rf_arb.sv
module tb_serv_rf_arb;
  localparam int WIDTH = 8;
  localparam int BEATS = 4;
  localparam int DEPTH = 64;
  localparam int L2D   = 6;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [L2D-1:0]   i_c_waddr, i_c_raddr;
  logic [WIDTH-1:0] i_c_wdata;
  logic             i_c_wen, i_c_ren;
  logic [WIDTH-1:0] o_c_rdata;
  logic             i_halted, i_clr_req, i_dbg_req, i_dbg_we;
  logic [4:0]       i_dbg_reg;
  logic [31:0]      i_dbg_wdata;
  logic             o_dbg_ack, o_dbg_err, o_busy;
  logic [31:0]      o_dbg_rdata;
  logic [L2D-1:0]   o_waddr, o_raddr;
  logic [WIDTH-1:0] o_wdata;
  logic             o_wen, o_ren;
  logic [WIDTH-1:0] i_rdata = '0;

  always #5 i_clk = ~i_clk;

  serv_rf_arb #(.WIDTH(WIDTH), .RF_COUNT(16), .CSR_COUNT(0), .CLR_ON_RESET(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_c_waddr(i_c_waddr), .i_c_wdata(i_c_wdata), .i_c_wen(i_c_wen),
    .i_c_raddr(i_c_raddr), .i_c_ren(i_c_ren), .o_c_rdata(o_c_rdata),
    .i_halted(i_halted), .i_clr_req(i_clr_req), .i_dbg_req(i_dbg_req),
    .i_dbg_we(i_dbg_we), .i_dbg_reg(i_dbg_reg), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_ack(o_dbg_ack), .o_dbg_err(o_dbg_err), .o_dbg_rdata(o_dbg_rdata),
    .o_busy(o_busy), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
    .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata)
  );

  // RAM model: 1-cycle synchronous read, seeded with non-zero garbage.
  logic [7:0] mem [DEPTH];
  bit         seeded = 1'b0;
  always @(posedge i_clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(8'hA5 ^ i);
      seeded <= 1'b1;
    end else if (o_wen) mem[o_waddr] <= o_wdata;
    if (o_ren) i_rdata <= mem[o_raddr];
  end

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Entered in the first CLR cycle; leaves in the following IDLE cycle.
  task automatic clr_seq();
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_beat", {o_wen, o_waddr, o_wdata}, {1'b1, 6'(i), 8'h00});
      tick();
    end
    chk("clr_done_busy", o_busy, 0);
  endtask

  // Issues one debug request; lat = edges from acceptance to the ack cycle.
  task automatic dbg(input logic we, input logic [4:0] r, input logic [31:0] wd,
                     input int lat, input logic exp_err, input logic [31:0] exp_rd,
                     input bit drop_halt);
    int n;
    int k;
    bit acked;
    i_dbg_req = 1'b1; i_dbg_we = we; i_dbg_reg = r; i_dbg_wdata = wd; i_halted = 1'b1;
    sb.push_back('{err: exp_err, rd: !we, rdata: exp_rd});
    n = 0; acked = 1'b0;
    while (!acked && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        // request fields must have been latched at acceptance
        i_dbg_reg = 5'd9; i_dbg_wdata = 32'h0BAD_F00D; i_dbg_we = !we;
      end
      if (n == 2 && drop_halt) i_halted = 1'b0;
      if (o_dbg_ack) acked = 1'b1;
      else begin
        k = n - 1;
        if (we && k < BEATS)
          chk("dwr_beat", {o_wen, o_ren, o_waddr, o_wdata},
              {1'b1, 1'b0, 6'(32'(r) * 4 + k), wd[k*8 +: 8]});
        else if (!we && k < BEATS)
          chk("drd_beat", {o_ren, o_wen, o_raddr}, {1'b1, 1'b0, 6'(32'(r) * 4 + k)});
        else
          chk("dbg_tail_idle_ram", {o_ren, o_wen}, 0);
      end
    end
    chk("dbg_latency", n - 1, lat);
    chk("ack_noram", {o_wen, o_ren}, 0);
    i_dbg_req = 1'b0;
    tick();
    chk("ack_one_cycle", o_dbg_ack, 0);
    i_halted = 1'b1;
  endtask

  // Completion monitor: every ack must match the oldest expected result.
  always @(negedge i_clk) begin
    if (i_rst_n && o_dbg_ack) begin
      vectors++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL ack_unexpected: observed ack=1 expected ack=0");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ack_err", o_dbg_err, e.err);
        if (e.rd) chk("ack_rdata", o_dbg_rdata, e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Core enables high during reset/INIT must not reach the RAM.
    i_c_waddr = 6'd33; i_c_wdata = 8'h77; i_c_wen = 1'b1;
    i_c_raddr = 6'd33; i_c_ren = 1'b1;
    i_halted = 1'b0; i_clr_req = 1'b0; i_dbg_req = 1'b0; i_dbg_we = 1'b0;
    i_dbg_reg = '0; i_dbg_wdata = '0;
    repeat (3) tick();
    chk("rst_busy", o_busy, 1);
    chk("rst_ram_en", {o_wen, o_ren}, 0);
    chk("rst_ack_err", {o_dbg_ack, o_dbg_err}, 0);
    chk("rst_rdata", o_dbg_rdata, 0);

    i_rst_n = 1'b1;
    #1;
    chk("init_busy", o_busy, 1);
    chk("init_ram_en", {o_wen, o_ren}, 0);
    tick();
    clr_seq();
    i_c_wen = 1'b0; i_c_ren = 1'b0;

    // Not halted: request ignored, core passes straight through.
    i_halted = 1'b0;
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = 5'd5; i_dbg_wdata = 32'hDEADBEEF;
    i_c_wen = 1'b1; i_c_waddr = 6'd10; i_c_wdata = 8'h5A;
    i_c_ren = 1'b1; i_c_raddr = 6'd10;
    #1;
    chk("pass_ports", {o_wen, o_waddr, o_wdata, o_ren, o_raddr},
        {1'b1, 6'd10, 8'h5A, 1'b1, 6'd10});
    tick();
    chk("pass_not_busy", {o_busy, o_dbg_ack}, 0);
    tick();
    chk("pass_rdata", o_c_rdata, 8'h5A);
    i_c_wen = 1'b0; i_c_ren = 1'b0;

    // Raising halted: accepted at the next edge.
    dbg(1'b1, 5'd5, 32'hDEADBEEF, 4, 1'b0, 32'h0, 1'b0);
    dbg(1'b0, 5'd5, 32'h0, 5, 1'b0, 32'hDEADBEEF, 1'b0);
    dbg(1'b0, 5'd2, 32'h0, 5, 1'b0, 32'h005A0000, 1'b0);
    dbg(1'b1, 5'd15, 32'h12345678, 4, 1'b0, 32'h0, 1'b0);
    chk("rdata_hold", o_dbg_rdata, 32'h005A0000);
    dbg(1'b0, 5'd15, 32'h0, 5, 1'b0, 32'h12345678, 1'b0);
    dbg(1'b0, 5'd0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    dbg(1'b1, 5'd0, 32'hFFFFFFFF, 0, 1'b0, 32'h0, 1'b0);
    dbg(1'b0, 5'd17, 32'h0, 0, 1'b1, 32'h0, 1'b0);

    // Clear and debug together: clear first, then the read (of cleared x5),
    // with halted dropped mid-read.
    i_clr_req = 1'b1; i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_reg = 5'd5;
    i_halted = 1'b1;
    tick();
    i_clr_req = 1'b0;
    clr_seq();
    dbg(1'b0, 5'd5, 32'h0, 5, 1'b0, 32'h0, 1'b1);

    // Reset mid-DWR: enables drop at once, no ack, clear restarts at 0.
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = 5'd7; i_dbg_wdata = 32'hCAFEF00D;
    i_halted = 1'b1;
    tick();
    tick();
    chk("dwr_pre_rst", {o_wen, o_waddr, o_wdata}, {1'b1, 6'd29, 8'hF0});
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_en", {o_wen, o_ren}, 0);
    chk("rst_mid_busy_ack", {o_busy, o_dbg_ack}, 32'h2);
    i_dbg_req = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("rel_init", {o_busy, o_wen}, 32'h2);
    tick();
    clr_seq();
    dbg(1'b0, 5'd7, 32'h0, 5, 1'b0, 32'h0, 1'b0);

    tick();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
